// File: rtl/mac_array_v2.sv
// Weight-stationary systolic MAC array with signed/unsigned modes and re-arm reload.
// Optional saturating accumulation is enabled by defining MAC_ARRAY_SAT_EN.
module mac_array_v2 #(
  parameter int bw      = 4,
  parameter int psum_bw = 16,
  parameter int row     = 8,
  parameter int col     = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [row*bw-1:0]      in_w,
  input  logic [1:0]             inst_w,
  input  logic [psum_bw*col-1:0] in_n,
  input  logic                   mode_signed,
  output logic [psum_bw*col-1:0] out_s,
  output logic [col-1:0]         valid
);

  localparam logic [1:0] INST_IDLE  = 2'b00;
  localparam logic [1:0] INST_LOAD  = 2'b01;
  localparam logic [1:0] INST_EXEC  = 2'b10;
  localparam logic [1:0] INST_REARM = 2'b11;

`ifdef MAC_ARRAY_SAT_EN
  localparam logic [psum_bw-1:0] SMAX = {1'b0, {(psum_bw-1){1'b1}}};
  localparam logic [psum_bw-1:0] SMIN = {1'b1, {(psum_bw-1){1'b0}}};
`endif

  // Nets between neighbouring tiles: eastward data/instructions, southward partial sums.
  logic [2*row-1:0]                 inst_row;
  logic [row*(col-1)*bw-1:0]        a_east;
  logic [row*(col-1)*2-1:0]         i_east;
  logic [(row-1)*col*psum_bw-1:0]   p_south;

  assign inst_row[1:0] = inst_w;

  for (genvar r = 0; r < row; r++) begin : g_row
    if (r > 0) begin : g_skew
      logic [1:0] inst_d;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) inst_d <= INST_IDLE;
        else       inst_d <= inst_row[2*(r-1) +: 2];
      end
      assign inst_row[2*r +: 2] = inst_d;
    end

    for (genvar c = 0; c < col; c++) begin : g_col
      logic [bw-1:0]          a_in;
      logic [bw-1:0]          w_q;
      logic [1:0]             inst_in;
      logic [psum_bw-1:0]     p_in;
      logic [psum_bw-1:0]     p_q;
      logic [psum_bw-1:0]     prod_ext;
      logic [psum_bw-1:0]     p_nxt;
      logic                   load_ready;
      logic [2*bw-1:0]        prod_u;
      logic signed [2*bw-1:0] prod_s;

      if (c == 0) begin : g_west
        assign a_in    = in_w[r*bw +: bw];
        assign inst_in = inst_row[2*r +: 2];
      end else begin : g_inner
        assign a_in    = a_east[(r*(col-1)+c-1)*bw +: bw];
        assign inst_in = i_east[(r*(col-1)+c-1)*2 +: 2];
      end

      if (r == 0) begin : g_top
        assign p_in = in_n[c*psum_bw +: psum_bw];
      end else begin : g_mid
        assign p_in = p_south[((r-1)*col+c)*psum_bw +: psum_bw];
      end

      assign prod_u   = (2*bw)'(a_in) * (2*bw)'(w_q);
      assign prod_s   = (2*bw)'($signed(a_in)) * (2*bw)'($signed(w_q));
      assign prod_ext = mode_signed ? psum_bw'(prod_s) : psum_bw'(prod_u);

`ifdef MAC_ARRAY_SAT_EN
      logic [psum_bw:0] sum_x;
      always_comb begin
        sum_x = '0;
        p_nxt = '0;
        if (mode_signed) begin
          sum_x = {p_in[psum_bw-1], p_in} + {prod_ext[psum_bw-1], prod_ext};
          p_nxt = sum_x[psum_bw-1:0];
          if (sum_x[psum_bw] != sum_x[psum_bw-1]) p_nxt = sum_x[psum_bw] ? SMIN : SMAX;
        end else begin
          sum_x = {1'b0, p_in} + {1'b0, prod_ext};
          p_nxt = sum_x[psum_bw-1:0];
          if (sum_x[psum_bw]) p_nxt = '1;
        end
      end
`else
      assign p_nxt = p_in + prod_ext;
`endif

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          w_q        <= '0;
          p_q        <= '0;
          load_ready <= 1'b1;
        end else begin
          case (inst_in)
            INST_LOAD: begin
              if (load_ready) begin
                w_q        <= a_in;
                load_ready <= 1'b0;
              end
            end
            INST_EXEC:  p_q        <= p_nxt;
            INST_REARM: load_ready <= 1'b1;
            default: ;
          endcase
        end
      end

      // East-edge tiles have no eastern neighbour, so their forwarding registers are not built.
      if (c < col-1) begin : g_fwd
        logic [bw-1:0] a_q;
        logic [1:0]    i_q;
        always_ff @(posedge clk or posedge reset) begin
          if (reset) begin
            a_q <= '0;
            i_q <= INST_IDLE;
          end else begin
            a_q <= a_in;
            i_q <= (inst_in == INST_LOAD && load_ready) ? INST_IDLE : inst_in;
          end
        end
        assign a_east[(r*(col-1)+c)*bw +: bw] = a_q;
        assign i_east[(r*(col-1)+c)*2 +: 2]   = i_q;
      end

      if (r == row-1) begin : g_out
        logic v_q;
        always_ff @(posedge clk or posedge reset) begin
          if (reset) v_q <= 1'b0;
          else       v_q <= (inst_in == INST_EXEC);
        end
        assign valid[c]                     = v_q;
        assign out_s[c*psum_bw +: psum_bw]  = p_q;
      end else begin : g_south
        assign p_south[(r*col+c)*psum_bw +: psum_bw] = p_q;
      end
    end
  end

endmodule

// File: tb/tb_mac_array_v2.sv
// Directed bench for mac_array_v2 (8x8, 4-bit lanes, 16-bit partial sums).
module tb_mac_array_v2;
  localparam int BW  = 4;
  localparam int PW  = 16;
  localparam int ROW = 8;
  localparam int COL = 8;
  localparam logic [1:0] I_IDLE  = 2'b00;
  localparam logic [1:0] I_LOAD  = 2'b01;
  localparam logic [1:0] I_EXEC  = 2'b10;
  localparam logic [1:0] I_REARM = 2'b11;

  logic              clk = 1'b0;
  logic              reset;
  logic [ROW*BW-1:0] in_w;
  logic [1:0]        inst_w;
  logic [PW*COL-1:0] in_n;
  logic              mode_signed;
  logic [PW*COL-1:0] out_s;
  logic [COL-1:0]    valid;

  int n_tests = 0;
  int n_fail  = 0;

  // Unskewed per-cycle values; lane r / column c is driven from the entry r / c cycles old.
  logic [BW-1:0] hist_a [16];
  logic [PW-1:0] hist_n [16];

  mac_array_v2 #(.bw(BW), .psum_bw(PW), .row(ROW), .col(COL)) dut (
    .clk(clk), .reset(reset), .in_w(in_w), .inst_w(inst_w), .in_n(in_n),
    .mode_signed(mode_signed), .out_s(out_s), .valid(valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_hist();
    for (int i = 0; i < 16; i++) begin
      hist_a[i] = '0;
      hist_n[i] = '0;
    end
    in_w   = '0;
    in_n   = '0;
    inst_w = I_IDLE;
  endtask

  task automatic cycle(input logic [1:0] inst, input logic [BW-1:0] a, input logic [PW-1:0] n);
    for (int i = 15; i > 0; i--) begin
      hist_a[i] = hist_a[i-1];
      hist_n[i] = hist_n[i-1];
    end
    hist_a[0] = a;
    hist_n[0] = n;
    inst_w = inst;
    for (int r = 0; r < ROW; r++) in_w[r*BW +: BW] = hist_a[r];
    for (int c = 0; c < COL; c++) in_n[c*PW +: PW] = hist_n[c];
    @(posedge clk);
    #1;
  endtask

  task automatic load_kernel(input logic [BW-1:0] base, input bit ramp);
    for (int j = 0; j < COL; j++)
      cycle(I_LOAD, ramp ? BW'(int'(base) + j) : base, '0);
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int c = 0; c < COL; c++)
      check($sformatf("%s_out_c%0d", tag, c), out_s[c*PW +: PW], '0);
    check($sformatf("%s_valid", tag), PW'(valid), '0);
  endtask

  // One execute, then idles until every column has reported; checks the valid skew and results.
  task automatic run_exec(input string tag, input logic [BW-1:0] a, input logic [PW-1:0] n,
                          input logic [PW*COL-1:0] exp);
    logic [COL-1:0] mask;
    cycle(I_EXEC, a, n);
    for (int t = 0; t < 16; t++) begin
      if (t > 0) cycle(I_IDLE, '0, '0);
      mask = '0;
      for (int c = 0; c < COL; c++) if (t == ROW-1+c) mask[c] = 1'b1;
      check($sformatf("%s_vld_t%0d", tag, t), PW'(valid), PW'(mask));
      if (t >= ROW-1 && t <= ROW+COL-2)
        check($sformatf("%s_out_c%0d", tag, t-ROW+1), out_s[(t-ROW+1)*PW +: PW],
              exp[(t-ROW+1)*PW +: PW]);
    end
  endtask

  initial begin
    reset       = 1'b1;
    mode_signed = 1'b0;
    clear_hist();
    #7;
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Ramp kernel: tile (r,c) holds c+1.
    load_kernel(4'd1, 1'b1);
    run_exec("ramp", 4'd1, 16'h0000, 128'h0040_0038_0030_0028_0020_0018_0010_0008);

    // A second kernel without re-arm must be ignored.
    load_kernel(4'd9, 1'b0);
    run_exec("reload_ignored", 4'd1, 16'h0000, 128'h0040_0038_0030_0028_0020_0018_0010_0008);

    cycle(I_REARM, '0, '0);
    load_kernel(4'hF, 1'b0);
    mode_signed = 1'b1;
    run_exec("negw_signed", 4'd2, 16'h0000, {COL{16'hFFF0}});
    mode_signed = 1'b0;
    run_exec("negw_unsigned", 4'd2, 16'h0000, {COL{16'h00F0}});

    cycle(I_REARM, '0, '0);
    load_kernel(4'd7, 1'b0);
    mode_signed = 1'b1;
`ifdef MAC_ARRAY_SAT_EN
    run_exec("overflow", 4'd7, 16'h7FF0, {COL{16'h7FFF}});
`else
    run_exec("overflow", 4'd7, 16'h7FF0, {COL{16'h8178}});
`endif
    mode_signed = 1'b0;

    cycle(I_REARM, '0, '0);
    load_kernel(4'd0, 1'b0);
    run_exec("zero_w", 4'd5, 16'h000A, {COL{16'h000A}});

    // Reset in the middle of an execute stream.
    cycle(I_REARM, '0, '0);
    load_kernel(4'd1, 1'b0);
    for (int i = 0; i < 10; i++) cycle(I_EXEC, 4'd1, 16'h0003);
    check("stream_valid", PW'(valid), 16'h0007);
    check("stream_out_c0", out_s[PW-1:0], 16'h000B);
    reset = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    clear_hist();
    @(posedge clk);
    #1;
    reset = 1'b0;
    run_exec("post_reset", 4'd5, 16'h0003, {COL{16'h0003}});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
